// File: rtl/clock_period_meter.sv
// Measures period and high time of a slow signal in clock_in cycles.
// sig_in is synchronized internally; results update with a one-cycle valid pulse.
module clock_period_meter #(
  parameter int CNT_W = 16
) (
  input  logic             clock_in,
  input  logic             reset,
  input  logic             enable,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period_out,
  output logic [CNT_W-1:0] high_out,
  output logic             valid,
  output logic             overflow,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, WAIT_RISE, MEASURE} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state, state_nxt;
  logic             s1, s2, s3;
  logic             rise;
  logic [CNT_W-1:0] period_cnt, period_cnt_nxt;
  logic [CNT_W-1:0] high_cnt, high_cnt_nxt;
  logic [CNT_W-1:0] period_out_nxt, high_out_nxt;
  logic             valid_nxt, overflow_nxt;

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= sig_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;
  assign busy = (state != IDLE);

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      period_cnt <= '0;
      high_cnt   <= '0;
      period_out <= '0;
      high_out   <= '0;
      valid      <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      state      <= state_nxt;
      period_cnt <= period_cnt_nxt;
      high_cnt   <= high_cnt_nxt;
      period_out <= period_out_nxt;
      high_out   <= high_out_nxt;
      valid      <= valid_nxt;
      overflow   <= overflow_nxt;
    end
  end

  // A rise in the same cycle as the all-ones count closes the period normally.
  always_comb begin
    state_nxt      = state;
    period_cnt_nxt = period_cnt;
    high_cnt_nxt   = high_cnt;
    period_out_nxt = period_out;
    high_out_nxt   = high_out;
    valid_nxt      = 1'b0;
    overflow_nxt   = overflow;
    if (!enable) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: state_nxt = WAIT_RISE;
        WAIT_RISE: begin
          if (rise) begin
            period_cnt_nxt = CNT_ONE;
            high_cnt_nxt   = CNT_ONE;
            state_nxt      = MEASURE;
          end
        end
        MEASURE: begin
          if (rise) begin
            period_out_nxt = period_cnt;
            high_out_nxt   = high_cnt;
            valid_nxt      = 1'b1;
            overflow_nxt   = 1'b0;
            period_cnt_nxt = CNT_ONE;
            high_cnt_nxt   = CNT_ONE;
          end else if (period_cnt == CNT_MAX) begin
            overflow_nxt = 1'b1;
            state_nxt    = WAIT_RISE;
          end else begin
            period_cnt_nxt = period_cnt + CNT_ONE;
            high_cnt_nxt   = high_cnt + CNT_W'(s2);
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_clock_period_meter.sv
// Self-checking bench: a 16-bit and a 4-bit meter see the same waveform,
// and reported periods are compared against a period-list model.
module tb_clock_period_meter;

  typedef struct {
    int p;
    int h;
  } meas_t;

  logic        clock_in = 1'b0;
  logic        reset;
  logic        enable;
  logic        sig_in;
  logic [15:0] p16, h16;
  logic [3:0]  p4, h4;
  logic        v16, ov16, b16;
  logic        v4, ov4, b4;

  int checks = 0;
  int errors = 0;

  meas_t got16[$];
  meas_t got4[$];
  int    dbl16 = 0, dbl4 = 0, ovv16 = 0, ovv4 = 0;
  logic  prev_v16 = 1'b0, prev_v4 = 1'b0;
  meas_t m16, m4;

  int hq[$];
  int lq[$];
  int last_p16 = 0, last_h16 = 0, last_p4 = 0, last_h4 = 0;
  int exp_ov4 = 0;

  clock_period_meter dut16 (
    .clock_in(clock_in), .reset(reset), .enable(enable), .sig_in(sig_in),
    .period_out(p16), .high_out(h16), .valid(v16), .overflow(ov16), .busy(b16)
  );

  clock_period_meter #(.CNT_W(4)) dut4 (
    .clock_in(clock_in), .reset(reset), .enable(enable), .sig_in(sig_in),
    .period_out(p4), .high_out(h4), .valid(v4), .overflow(ov4), .busy(b4)
  );

  always #5 clock_in = ~clock_in;

  // Record every reported measurement and any valid that lasts two cycles.
  always @(negedge clock_in) begin
    if (v16) begin
      m16.p = int'(p16);
      m16.h = int'(h16);
      got16.push_back(m16);
      if (prev_v16) dbl16++;
      if (ov16) ovv16++;
    end
    if (v4) begin
      m4.p = int'(p4);
      m4.h = int'(h4);
      got4.push_back(m4);
      if (prev_v4) dbl4++;
      if (ov4) ovv4++;
    end
    prev_v16 = v16;
    prev_v4  = v4;
  end

  // Drives the periods in hq/lq, closed by one extra rise, then disables.
  task automatic run_burst(input string name);
    meas_t exp16[$];
    meas_t exp4[$];
    meas_t e;
    got16.delete();
    got4.delete();
    dbl16 = 0; dbl4 = 0; ovv16 = 0; ovv4 = 0;
    @(negedge clock_in);
    sig_in = 1'b0;
    repeat (3) @(negedge clock_in);
    enable = 1'b1;
    repeat (2) @(negedge clock_in);
    for (int i = 0; i < hq.size(); i++) begin
      sig_in = 1'b1;
      repeat (hq[i]) @(negedge clock_in);
      sig_in = 1'b0;
      repeat (lq[i]) @(negedge clock_in);
      e.p = hq[i] + lq[i];
      e.h = hq[i];
      exp16.push_back(e);
      last_p16 = e.p;
      last_h16 = e.h;
      if (e.p <= 15) begin
        exp4.push_back(e);
        last_p4 = e.p;
        last_h4 = e.h;
        exp_ov4 = 0;
      end else begin
        exp_ov4 = 1;
      end
    end
    sig_in = 1'b1;
    @(negedge clock_in);
    sig_in = 1'b0;
    repeat (6) @(negedge clock_in);

    checks++;
    if (got16.size() !== exp16.size()) begin
      errors++;
      $display("[TB] FAIL %s count16 got %0d want %0d", name, got16.size(), exp16.size());
    end
    for (int i = 0; i < exp16.size() && i < got16.size(); i++) begin
      checks++;
      if (got16[i].p !== exp16[i].p || got16[i].h !== exp16[i].h) begin
        errors++;
        $display("[TB] FAIL %s meas16[%0d] got p=%0d h=%0d want p=%0d h=%0d",
                 name, i, got16[i].p, got16[i].h, exp16[i].p, exp16[i].h);
      end
    end
    checks++;
    if (got4.size() !== exp4.size()) begin
      errors++;
      $display("[TB] FAIL %s count4 got %0d want %0d", name, got4.size(), exp4.size());
    end
    for (int i = 0; i < exp4.size() && i < got4.size(); i++) begin
      checks++;
      if (got4[i].p !== exp4[i].p || got4[i].h !== exp4[i].h) begin
        errors++;
        $display("[TB] FAIL %s meas4[%0d] got p=%0d h=%0d want p=%0d h=%0d",
                 name, i, got4[i].p, got4[i].h, exp4[i].p, exp4[i].h);
      end
    end
    checks++;
    if (int'(p16) !== last_p16 || int'(h16) !== last_h16 || ov16 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s final16 got p=%0d h=%0d ov=%0b want p=%0d h=%0d ov=0",
               name, p16, h16, ov16, last_p16, last_h16);
    end
    checks++;
    if (int'(p4) !== last_p4 || int'(h4) !== last_h4 || int'(ov4) !== exp_ov4) begin
      errors++;
      $display("[TB] FAIL %s final4 got p=%0d h=%0d ov=%0b want p=%0d h=%0d ov=%0d",
               name, p4, h4, ov4, last_p4, last_h4, exp_ov4);
    end
    checks++;
    if (dbl16 !== 0 || dbl4 !== 0 || ovv16 !== 0 || ovv4 !== 0) begin
      errors++;
      $display("[TB] FAIL %s valid_shape got dbl=%0d/%0d ov_at_valid=%0d/%0d want all 0",
               name, dbl16, dbl4, ovv16, ovv4);
    end
    enable = 1'b0;
    @(negedge clock_in);
    hq.delete();
    lq.delete();
  endtask

  task automatic check_zero(input string name);
    checks++;
    if (p16 !== 16'd0 || h16 !== 16'd0 || v16 !== 1'b0 || ov16 !== 1'b0 || b16 !== 1'b0 ||
        p4 !== 4'd0 || h4 !== 4'd0 || v4 !== 1'b0 || ov4 !== 1'b0 || b4 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s got p16=%0d h16=%0d v=%0b ov=%0b b=%0b p4=%0d h4=%0d v=%0b ov=%0b b=%0b want all 0",
               name, p16, h16, v16, ov16, b16, p4, h4, v4, ov4, b4);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    enable = 1'b0;
    sig_in = 1'b0;
    repeat (3) @(negedge clock_in);
    check_zero("reset_hold");
    reset = 1'b0;
    repeat (2) @(negedge clock_in);
    check_zero("reset_release");
  endtask

  task automatic test_divide_by_4();
    for (int i = 0; i < 4; i++) begin hq.push_back(2); lq.push_back(2); end
    run_burst("div4");
  endtask

  task automatic test_fastest();
    for (int i = 0; i < 5; i++) begin hq.push_back(1); lq.push_back(1); end
    run_burst("fastest");
  endtask

  task automatic test_asymmetric();
    for (int i = 0; i < 3; i++) begin hq.push_back(3); lq.push_back(7); end
    run_burst("asym");
  endtask

  task automatic test_overflow();
    hq.push_back(1); lq.push_back(20);
    run_burst("overflow_stuck");
    hq.push_back(3); lq.push_back(3);
    run_burst("overflow_recover");
    hq.push_back(4); lq.push_back(11);
    run_burst("boundary_15");
    hq.push_back(4); lq.push_back(12);
    run_burst("boundary_16");
  endtask

  task automatic test_enable_control();
    got16.delete();
    got4.delete();
    sig_in = 1'b0;
    enable = 1'b1;
    repeat (3) @(negedge clock_in);
    sig_in = 1'b1;
    repeat (2) @(negedge clock_in);
    sig_in = 1'b0;
    repeat (3) @(negedge clock_in);
    checks++;
    if (b16 !== 1'b1 || b4 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL en_busy_on got %0b/%0b want 1/1", b16, b4);
    end
    enable = 1'b0;
    @(negedge clock_in);
    checks++;
    if (b16 !== 1'b0 || b4 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL en_busy_off got %0b/%0b want 0/0", b16, b4);
    end
    for (int i = 0; i < 3; i++) begin
      sig_in = 1'b1;
      repeat (2) @(negedge clock_in);
      sig_in = 1'b0;
      repeat (2) @(negedge clock_in);
    end
    checks++;
    if (got16.size() !== 0 || got4.size() !== 0 || int'(p16) !== last_p16 ||
        int'(p4) !== last_p4 || int'(ov4) !== exp_ov4) begin
      errors++;
      $display("[TB] FAIL en_hold got n=%0d/%0d p=%0d/%0d ov4=%0b want n=0/0 p=%0d/%0d ov4=%0d",
               got16.size(), got4.size(), p16, p4, ov4, last_p16, last_p4, exp_ov4);
    end
    hq.push_back(5); lq.push_back(3);
    run_burst("reenable");
  endtask

  task automatic test_random();
    for (int b = 0; b < 4; b++) begin
      int n;
      n = 3 + int'($urandom_range(3));
      for (int i = 0; i < n; i++) begin
        hq.push_back(1 + int'($urandom_range(7)));
        lq.push_back(1 + int'($urandom_range(11)));
      end
      run_burst($sformatf("random%0d", b));
    end
  endtask

  task automatic test_async_reset();
    hq.push_back(3); lq.push_back(4);
    run_burst("pre_reset");
    enable = 1'b1;
    sig_in = 1'b1;
    repeat (4) @(negedge clock_in);
    sig_in = 1'b0;
    repeat (2) @(negedge clock_in);
    @(posedge clock_in);
    #2;
    reset = 1'b1;
    #1;
    check_zero("async_reset");
    last_p16 = 0; last_h16 = 0; last_p4 = 0; last_h4 = 0; exp_ov4 = 0;
    @(negedge clock_in);
    reset = 1'b0;
    enable = 1'b0;
    @(negedge clock_in);
    hq.push_back(2); lq.push_back(5);
    run_burst("post_reset");
  endtask

  initial begin
    test_reset();
    test_divide_by_4();
    test_fastest();
    test_asymmetric();
    test_overflow();
    test_enable_control();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
